seq_muldiv: RTL

SEQ_MULDIV -- requirements
Module: seq_muldiv

---
 rtl/seq_muldiv_pkg.sv | 17 +
 rtl/seq_muldiv_step.sv | 44 ++++
 rtl/seq_muldiv.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_muldiv_pkg.sv
// Shared definitions for the sequential multiplier/divider.
// Provides the FSM state encoding, the OP select constants and the default
// operand width used by seq_muldiv and muldiv_step.
package seq_muldiv_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_muldiv_step.sv
// One iteration of the sequential multiply / restoring divide (pure combinational).
// Ports: acc_i   - 2*WIDTH accumulator ({hi, lo}); op_b_i - multiplicand or divisor;
//        op_i    - OP_MUL / OP_DIV;  acc_d_o - accumulator after this step.
module muldiv_step
  import seq_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   op_b_i,
  input  logic               op_i,
  output logic [2*WIDTH-1:0] acc_d_o
);

  // Multiply: lo holds the not-yet-consumed multiplier bits. Add the
  // multiplicand into hi when the current LSB is set, then shift the whole
  // {carry, hi, lo} right; the carry bit keeps the full product.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;

  assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                 + (acc_i[0] ? {1'b0, op_b_i} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_i[WIDTH-1:1]};

  // Divide: hi is the partial remainder, lo shifts the dividend out at the
  // top and the quotient bits in at the bottom. The shifted remainder needs
  // one extra bit before the trial subtraction.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_nxt;
  logic [2*WIDTH-1:0]   div_nxt;

  assign rem_sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, op_b_i};
  assign q_bit    = (rem_sh >= {1'b0, op_b_i});
  // After a successful subtract the remainder is below the divisor, so it
  // always fits back into WIDTH bits.
  assign rem_nxt  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_nxt  = {rem_nxt, acc_i[WIDTH-2:0], q_bit};

  assign acc_d_o = (op_i == OP_DIV) ? div_nxt : mul_nxt;

endmodule

// File: rtl/seq_muldiv.sv
// Sequential unsigned multiplier / restoring divider, one step per cycle.
// Ports: CLK/RST (async active-high); START, OP, X, A request an operation;
//        Y = product or {remainder, quotient}; BUSY while iterating; DONE pulse; DIVZ.
module seq_muldiv
  import seq_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               OP,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   A,
  output logic [2*WIDTH-1:0] Y,
  output logic               BUSY,
  output logic               DONE,
  output logic               DIVZ
);

  localparam int               CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     a_q;
  logic                 op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   y_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 divz_q;
  logic [WIDTH-1:0]     step_b;

  // Multiply adds the multiplicand; divide subtracts the divisor.
  assign step_b = (op_q == OP_MUL) ? x_q : a_q;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .op_b_i  (step_b),
    .op_i    (op_q),
    .acc_d_o (acc_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      a_q     <= '0;
      op_q    <= OP_MUL;
      acc_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          if (START) begin
            x_q    <= X;
            a_q    <= A;
            op_q   <= OP;
            cnt_q  <= '0;
            divz_q <= 1'b0;
            if (OP == OP_DIV && A == '0) begin
              // Zero divisor: no iterations, report immediately.
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              divz_q  <= 1'b1;
              y_q     <= {X, {WIDTH{1'b1}}};
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              // Multiply streams the multiplier through lo; divide streams
              // the dividend through lo. hi starts at zero for both.
              acc_q   <= (OP == OP_MUL) ? {{WIDTH{1'b0}}, A}
                                        : {{WIDTH{1'b0}}, X};
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            y_q     <= acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DIVZ = divz_q;

endmodule
